// File: rtl/router_pkg.sv
// router_pkg: shared router sizing, index/vector types and port naming
package router_pkg;
  localparam int NUM_PORTS = 5;
  localparam int NUM_VC = 2;
  localparam int PTR_W = NUM_PORTS > 1 ? $clog2(NUM_PORTS) : 1;
  typedef logic [NUM_PORTS-1:0] port_vec_t;
  typedef logic [PTR_W-1:0] port_idx_t;
  typedef logic [NUM_VC-1:0] vc_vec_t;
  typedef enum port_idx_t {LOCAL, NORTH, EAST, SOUTH, WEST} port_name_e;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter; the pointer moves past the winner only when told to
module rr_arbiter #(
  parameter int N = 5,
  localparam int PW = N > 1 ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          update_en,
  input  logic [PW-1:0] upd_idx,
  output logic [N-1:0]  gnt
);
  logic [PW-1:0] ptr;
  logic [N-1:0]  hi;
  // requests at or above the pointer win first; otherwise wrap to the lowest request
  always_comb begin
    hi = req & ~((N'(1) << ptr) - N'(1));
    gnt = |hi ? hi & (~hi + N'(1)) : req & (~req + N'(1));
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= '0;
    else if (update_en) ptr <= (upd_idx == PW'(N-1)) ? '0 : upd_idx + 1'b1;
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first round-robin switch allocator with registered grants
module switch_allocator
  import router_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  port_vec_t port_req [NUM_PORTS],
  input  port_vec_t credit_avail,
  output port_vec_t in_grant [NUM_PORTS],
  output port_vec_t xbar_sel [NUM_PORTS],
  output port_vec_t xbar_valid
);
  port_vec_t in_pick [NUM_PORTS];
  port_vec_t out_req [NUM_PORTS];
  port_vec_t out_win [NUM_PORTS];
  port_vec_t grant [NUM_PORTS];
  port_vec_t grant_t [NUM_PORTS];
  port_vec_t valid;
  port_idx_t in_idx [NUM_PORTS];
  port_idx_t out_idx [NUM_PORTS];
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_arb
    rr_arbiter #(.N(NUM_PORTS)) u_in (
      .clk(clk), .rst_n(rst_n), .req(port_req[i] & credit_avail),
      .update_en(|grant[i]), .upd_idx(in_idx[i]), .gnt(in_pick[i])
    );
    rr_arbiter #(.N(NUM_PORTS)) u_out (
      .clk(clk), .rst_n(rst_n), .req(out_req[i]),
      .update_en(|grant_t[i]), .upd_idx(out_idx[i]), .gnt(out_win[i])
    );
  end
  always_comb begin
    out_req = '{default: '0};
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = 0; j < NUM_PORTS; j++) out_req[j][i] = in_pick[i][j];
  end
  // a final grant needs both the input's pick and the output's acceptance
  always_comb begin
    grant = '{default: '0};
    grant_t = '{default: '0};
    for (int i = 0; i < NUM_PORTS; i++)
      for (int j = 0; j < NUM_PORTS; j++) begin
        grant[i][j] = in_pick[i][j] & out_win[j][i];
        grant_t[j][i] = grant[i][j];
      end
  end
  always_comb begin
    in_idx = '{default: '0};
    out_idx = '{default: '0};
    valid = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      valid[i] = |grant_t[i];
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (grant[i][j]) in_idx[i] = port_idx_t'(j);
        if (grant_t[i][j]) out_idx[i] = port_idx_t'(j);
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      in_grant <= '{default: '0};
      xbar_sel <= '{default: '0};
      xbar_valid <= '0;
    end else begin
      in_grant <= grant;
      xbar_sel <= grant_t;
      xbar_valid <= valid;
    end
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: random and directed stimulus checked against an index-level allocation model
module tb_switch_allocator;
  import router_pkg::*;
  localparam int P = NUM_PORTS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  port_vec_t port_req [P];
  port_vec_t credit_avail;
  port_vec_t in_grant [P];
  port_vec_t xbar_sel [P];
  port_vec_t xbar_valid;

  int vectors = 0;
  int errors = 0;
  int in_ptr [P];
  int out_ptr [P];
  port_vec_t exp_in [P];
  port_vec_t exp_xs [P];
  port_vec_t exp_v;
  port_vec_t s_req [P];
  port_vec_t s_cr;
  port_vec_t tr;
  int age [P][P];
  int max_age;
  bit starv_en = 1'b0;

  always #5 clk = ~clk;

  switch_allocator dut (
    .clk(clk), .rst_n(rst_n), .port_req(port_req), .credit_avail(credit_avail),
    .in_grant(in_grant), .xbar_sel(xbar_sel), .xbar_valid(xbar_valid)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] @%0t: got 0x%0h, expected 0x%0h", name, idx, $time, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < P; i++) begin
      in_ptr[i] = 0;
      out_ptr[i] = 0;
      exp_in[i] = '0;
      exp_xs[i] = '0;
    end
  endfunction

  // Each input picks its first credited request from its pointer; each output
  // accepts the first picking input from its pointer; winners move both pointers.
  function automatic void model_step();
    int pick [P];
    int win [P];
    int j, i;
    for (int a = 0; a < P; a++) begin
      pick[a] = -1;
      for (int k = 0; k < P; k++) begin
        j = (in_ptr[a] + k) % P;
        if (pick[a] < 0 && port_req[a][j] && credit_avail[j]) pick[a] = j;
      end
    end
    for (int b = 0; b < P; b++) begin
      win[b] = -1;
      for (int k = 0; k < P; k++) begin
        i = (out_ptr[b] + k) % P;
        if (win[b] < 0 && pick[i] == b) win[b] = i;
      end
    end
    for (int a = 0; a < P; a++) begin
      exp_in[a] = '0;
      exp_xs[a] = '0;
    end
    for (int b = 0; b < P; b++)
      if (win[b] >= 0) begin
        i = win[b];
        exp_in[i][b] = 1'b1;
        exp_xs[b][i] = 1'b1;
        in_ptr[i] = (b + 1) % P;
        out_ptr[b] = (i + 1) % P;
      end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else begin
      s_req = port_req;
      s_cr = credit_avail;
      model_step();
    end
    #1;
    exp_v = '0;
    for (int j = 0; j < P; j++) exp_v[j] = exp_xs[j] != '0;
    check("xbar_valid", 0, xbar_valid, exp_v);
    for (int i = 0; i < P; i++) begin
      check("in_grant", i, in_grant[i], exp_in[i]);
      check("xbar_sel", i, xbar_sel[i], exp_xs[i]);
      check("onehot_in", i, $onehot0(in_grant[i]), 1);
      check("onehot_xs", i, $onehot0(xbar_sel[i]), 1);
      for (int j = 0; j < P; j++) tr[j] = xbar_sel[j][i];
      check("transpose", i, in_grant[i], tr);
    end
    if (starv_en && rst_n) begin
      max_age = 0;
      for (int i = 0; i < P; i++)
        for (int j = 0; j < P; j++) begin
          if (in_grant[i][j]) age[i][j] = 0;
          else if (s_req[i][j] && s_cr[j]) age[i][j]++;
          else age[i][j] = 0;
          if (age[i][j] > max_age) max_age = age[i][j];
        end
      check("starve_age", 0, max_age <= P * P, 1);
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_req();
    for (int i = 0; i < P; i++) port_req[i] = '0;
    credit_avail = '1;
  endtask

  task automatic do_reset();
    clear_req();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  port_vec_t seq_out [4] = '{5'b00001, 5'b00010, 5'b01000, 5'b00001};
  port_vec_t seq_in [4] = '{5'b00001, 5'b00010, 5'b10000, 5'b00001};
  int g0;

  initial begin
    clear_req();
    tick(2);
    check("rst_in_grant", 1, in_grant[1], 0);
    check("rst_valid", 0, xbar_valid, 0);
    rst_n = 1'b1;
    port_req[1] = 5'b00100;
    tick();
    check("lit_in_grant", 1, in_grant[1], 5'b00100);
    check("lit_xbar_sel", 2, xbar_sel[2], 5'b00010);
    check("lit_valid", 0, xbar_valid, 5'b00100);
    rst_n = 1'b0;
    #1;
    check("async_rst_in", 1, in_grant[1], 0);
    check("async_rst_valid", 0, xbar_valid, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_grant", 1, in_grant[1], 5'b00100);

    do_reset();
    port_req[0] = 5'b10000;
    port_req[1] = 5'b10000;
    port_req[3] = 5'b10000;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("out_contention", k, xbar_sel[4], seq_out[k]);
    end

    do_reset();
    port_req[2] = 5'b10011;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("in_contention", k, in_grant[2], seq_in[k]);
    end

    do_reset();
    port_req[0] = 5'b00110;
    credit_avail = 5'b11011;
    tick();
    check("credit_mask", 0, in_grant[0], 5'b00010);
    credit_avail = 5'b00000;
    tick();
    check("no_credit_grant", 0, in_grant[0], 0);
    check("no_credit_valid", 0, xbar_valid, 0);
    credit_avail = 5'b11111;
    tick();
    check("credit_restore", 0, in_grant[0], 5'b00100);

    do_reset();
    port_req[0] = 5'b01000;
    tick();
    port_req[0] = 5'b00100;
    tick();
    port_req[0] = 5'b01100;
    port_req[1] = 5'b01000;
    tick();
    check("s1_loss_in0", 0, in_grant[0], 0);
    check("s1_loss_in1", 1, in_grant[1], 5'b01000);
    check("s1_loss_sel3", 3, xbar_sel[3], 5'b00010);
    tick();
    check("s1_retry_in0", 0, in_grant[0], 5'b01000);
    g0 = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (in_grant[0][3]) g0++;
    end
    check("s1_no_starve", 0, g0 > 0, 1);

    do_reset();
    for (int i = 0; i < P; i++)
      for (int j = 0; j < P; j++) age[i][j] = 0;
    starv_en = 1'b1;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < P; i++) port_req[i] = port_vec_t'($urandom);
      tick(30);
    end
    starv_en = 1'b0;

    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < P; i++)
        port_req[i] = ($urandom_range(0, 3) == 0) ? '0 : port_vec_t'($urandom);
      credit_avail = ($urandom_range(0, 15) == 0) ? '0 : port_vec_t'($urandom | $urandom);
      if ($urandom_range(0, 1999) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
Name: switch_allocator

Overview:
- Separable input-first switch allocator, directly downstream of the VC-grant-to-port-request conversion stage.
- Consumes per-input-port output-port request vectors plus per-output credit availability.
- Produces registered crossbar selects and per-input grants for the switch traversal stage.
- Round-robin fairness at both input and output stages; priority pointers advance only on final grants.

Parameters:
- NUM_PORTS, 5, router ports; inputs and outputs symmetric.
- NUM_VC, 2, VCs per port; carried for package consistency, no effect on allocation logic.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- port_req  input  [NUM_PORTS-1:0] x NUM_PORTS (unpacked by input port)  port_req[i][j]=1: input i requests output j.
- credit_avail  input  NUM_PORTS  bit j=1: output j's downstream has at least one free buffer this cycle.
- in_grant  output  [NUM_PORTS-1:0] x NUM_PORTS (unpacked by input port)  registered; in_grant[i] one-hot output granted to input i, or zero.
- xbar_sel  output  [NUM_PORTS-1:0] x NUM_PORTS (unpacked by output port)  registered; xbar_sel[j] one-hot input driving output j, or zero.
- xbar_valid  output  NUM_PORTS  registered; bit j = |xbar_sel[j].

Behaviour:
- Reset (rst_n=0, async): in_grant, xbar_sel, xbar_valid all 0; all input and output pointers 0.
- Masking: eff_req[i][j] = port_req[i][j] & credit_avail[j]. Requests to outputs without credit are invisible to both stages.
- Stage 1, per input i:
  - Round-robin arbiter over eff_req[i] with pointer in_ptr[i].
  - Winner = first set bit at index >= in_ptr[i], wrapping modulo NUM_PORTS.
  - Result: one-hot in_pick[i].
- Stage 2, per output j:
  - Request vector is {in_pick[i][j] for all i}.
  - Round-robin arbiter with pointer out_ptr[j]; same wrap rule.
  - Result: one-hot out_win[j].
- Final grant: g[i][j] = in_pick[i][j] & out_win[j][i]. Combinational within the cycle.
- Latency: requests sampled at edge N appear on in_grant/xbar_sel at edge N+1. Outputs are flops, fully registered.
- Pointer update, only on final grant:
  - in_ptr[i] <= (j+1) mod NUM_PORTS when input i is granted output j.
  - out_ptr[j] <= (i+1) mod NUM_PORTS when output j grants input i.
  - A losing stage-1 pick leaves in_ptr[i] unchanged (iSLIP-style; guarantees no starvation).
- Wrap-around: pointer value NUM_PORTS-1 advancing yields 0. Pointer width is $clog2(NUM_PORTS), minimum 1.
- No request, or all credits 0: all grant outputs 0 next cycle; pointers hold.
- Invariants every cycle:
  - Each in_grant[i] and each xbar_sel[j] has at most one bit set.
  - in_grant[i][j] == xbar_sel[j][i].
  - xbar_valid[j] == |xbar_sel[j].
- Simultaneous events: a request and a credit drop in the same cycle use the sampled credit value; no credit lookahead.
- No internal request storage. A request not granted must be re-presented by upstream next cycle.
- Reset mid-operation: outputs clear immediately (async). Pointers return to 0. First post-reset grant uses pointers at 0.
- Self-port requests (i==j) are legal and arbitrated like any other.

Decomposition:
- Shared package router_pkg:
  - NUM_PORTS/NUM_VC defaults.
  - typedef port_vec_t = logic [NUM_PORTS-1:0].
  - typedef port_idx_t = logic [$clog2(NUM_PORTS)-1:0].
  - Port index constants (LOCAL, NORTH, EAST, SOUTH, WEST = 0..4).
- Sub-module rr_arbiter:
  - Parameter N.
  - Inputs: req[N], update_en, upd_idx; output: one-hot gnt.
  - Internal pointer flop with async active-low reset; combinational grant from current pointer.
  - Instantiated NUM_PORTS times per stage (2*NUM_PORTS total).

Test Plan:
- Reset: rst_n=0 asserted mid-grant -> outputs 0 within the same cycle; after release, port_req[1]=5'b00100, credit=5'b11111 -> cycle+1 in_grant[1]=00100, xbar_sel[2]=00010, xbar_valid=00100.
- Output contention: inputs 0,1,3 all request output 4 for 4 cycles, full credit -> xbar_sel[4] sequence 00001, 00010, 01000, 00001 (pointer wrap).
- Input contention: port_req[2]=5'b10011 held 4 cycles, full credit -> in_grant[2] sequence 00001, 00010, 10000, 00001.
- Credit mask: port_req[0]=5'b00110, credit_avail=5'b11011 -> in_grant[0]=00010; credit_avail=5'b00000 -> all outputs 0, pointers unchanged (next credit-restored grant matches pre-stall order).
- Stage-1 loss: inputs 0 and 1 both pick output 3; input 0 also requests output 2 -> input 1 wins output 3 per out_ptr; in_ptr[0] is unchanged and it retries output 3 next cycle, never starving over 10 cycles.
- Randomised 5x5 with random credits, 10k cycles -> one-hot invariants, in_grant/xbar_sel transpose equality, and every persistent request granted within NUM_PORTS*NUM_PORTS cycles.
